// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub
//   Packed-BCD adder/subtractor that works one decimal digit per clock,
//   least-significant digit first. One operand set is accepted in IDLE. The
//   result is ready DIGITS cycles later and is held in DONE until the consumer
//   takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The producer holds data stable while valid is high and ready
//   is low. Valid never depends combinationally on ready.
//   in_ready is high only in IDLE. out_valid is high only in DONE.
//
// Optional feature: define BCD_DIGIT_CHECK_EN to add the err output. It flags
//   any operand digit above 9. While err=1, sum and cout are forced to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand set a/b/cin/sub is valid
//   in_ready   block can accept operands (IDLE)
//   a, b       packed BCD operands, digit 0 = [3:0]
//   cin        add: carry-in, sub: borrow-in
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  sum/cout valid (DONE)
//   out_ready  consumer accepts the result
//   sum        packed BCD result
//   cout       add: decimal carry-out, sub: borrow-out
//   err        (BCD_DIGIT_CHECK_EN only) non-BCD digit seen at accept
//   dbg_state  current FSM state, for observation
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
`ifdef BCD_DIGIT_CHECK_EN
  output logic                err,
`endif
  output logic [1:0]          dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          c_q, c_d;
  logic          cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [W-1:0]  b_eff;
  logic [4:0]    t;
  logic          digit_c;
  logic [3:0]    digit;

  // Subtraction adds the nines' complement of b. The carry starts at ~cin,
  // so a - b - cin becomes a + (99..9 - b) + 1 - cin.
  always_comb begin
    b_eff = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b_eff[4*k +: 4] = sub ? (4'd9 - b[4*k +: 4]) : b[4*k +: 4];
    end
  end

  // One decimal digit step on the low digit of the shifting operands.
  always_comb begin
    t       = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    digit_c = (t > 5'd9);
    digit   = digit_c ? (t[3:0] + 4'd6) : t[3:0];
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_flag_q, err_flag_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    c_d     = c_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_flag_d = err_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          sub_d   = sub;
          c_d     = sub ? ~cin : cin;
          idx_d   = '0;
          state_d = S_CALC;
`ifdef BCD_DIGIT_CHECK_EN
          err_flag_d = bad_digit;
`endif
        end
      end
      S_CALC: begin
        // Operands shift right one digit per cycle. Result digits enter at
        // the top of sum, so after DIGITS steps digit 0 sits in sum[3:0].
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = digit_c;
        sum_d = (sum_q >> 4) | (W'(digit) << (W - 4));
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = sub_q ? ~digit_c : digit_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_flag_q <= err_flag_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign dbg_state = state_q;

`ifdef BCD_DIGIT_CHECK_EN
  assign err  = (state_q == S_DONE) && err_flag_q;
  assign sum  = err ? '0 : sum_q;
  assign cout = cout_q && !err;
`else
  assign sum  = sum_q;
  assign cout = cout_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub with DIGITS=4. Expected results come from an
// integer model of decimal add/subtract with modulo 10^DIGITS wrap.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef BCD_DIGIT_CHECK_EN
    .err       (err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry layout: {err, cout, sum}
  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic r = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rc, input logic rs);
    int m = pow10(DIGITS);
    int r;
    logic co;
`ifdef BCD_DIGIT_CHECK_EN
    if (has_bad(ra) || has_bad(rb)) return {1'b1, 1'b0, {W{1'b0}}};
`endif
    if (!rs) begin
      r  = bcd2int(ra) + bcd2int(rb) + int'(rc);
      co = (r >= m);
      r  = r % m;
    end else begin
      r  = bcd2int(ra) - bcd2int(rb) - int'(rc);
      co = (r < 0);
      if (r < 0) r = r + m;
    end
    return {1'b0, co, int2bcd(r)};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation, checks latency, optionally stalls the consumer
  // while poking in_valid, then checks the result and the return to IDLE.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic rc, input logic rs, input int stall);
    logic [W+1:0] e;
    int lat;
    exp_q.push_back(ref_op(ra, rb, rc, rs));
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("out_valid_seen", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(DIGITS));
    e = exp_q[0];
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = rand_bcd(); b = rand_bcd();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(e[W-1:0]));
      check("stall_cout", 32'(cout), 32'(e[W]));
      @(posedge clk);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("sum", 32'(sum), 32'(e[W-1:0]));
    check("cout", 32'(cout), 32'(e[W]));
`ifdef BCD_DIGIT_CHECK_EN
    check("err", 32'(err), 32'(e[W+1]));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("back_to_idle_ready", 32'(in_ready), 32'd1);
    check("back_to_idle_valid", 32'(out_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    int lat;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif

    // Directed cases
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0009, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0500, 16'h0123, 1'b0, 1'b1, 0);
    run_op(16'h0123, 16'h0500, 1'b0, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
    run_op(16'h9999, 16'h9999, 1'b1, 1'b0, 0);
    run_op(16'h0042, 16'h0042, 1'b0, 1'b1, 0);
    run_op(16'h0042, 16'h0041, 1'b1, 1'b1, 0);
    run_op(16'h2468, 16'h1357, 1'b0, 1'b0, 5);

    // Reset during the second CALC cycle aborts the operation
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
    check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
    check("midcalc_rst_sum", 32'(sum), 32'd0);
    // Make sure nothing from the aborted op surfaces later
    lat = 0;
    repeat (DIGITS + 2) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("midcalc_no_result", 32'(lat), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef BCD_DIGIT_CHECK_EN
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 2);
    run_op(16'h0001, 16'hF000, 1'b1, 1'b1, 0);
    run_op(16'h1234, 16'h0001, 1'b0, 1'b0, 0);
`endif

    // Randomized operations with random consumer stalls
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
`ifdef BCD_DIGIT_CHECK_EN
      if ($urandom_range(0, 4) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
